// File: rtl/motion_update_broadcaster.sv
// Motion-update broadcast transmitter: scans every cell, resolves each particle's destination cell and broadcasts it.
// Optional MU_BROADCAST_STALL_EN adds in_stall, which pauses read issue while in-flight reads drain.

module mu_axis_resolve #(
  parameter int DATA_WIDTH    = 32,
  parameter int CELL_ID_WIDTH = 4,
  parameter int CELL_NUM      = 4
)(
  input  logic [DATA_WIDTH-1:0]    comp,
  input  logic [CELL_ID_WIDTH-1:0] src,
  output logic [DATA_WIDTH-1:0]    comp_clr,
  output logic [CELL_ID_WIDTH-1:0] dst
);
  localparam logic [CELL_ID_WIDTH-1:0] NC  = CELL_ID_WIDTH'(CELL_NUM);
  localparam logic [CELL_ID_WIDTH-1:0] ONE = CELL_ID_WIDTH'(1);

  always_comb begin
    comp_clr = comp;
    comp_clr[DATA_WIDTH-1 -: 2] = 2'b00;
    dst = src;
    // 10 is not a legal crossing code and is treated as stay
    case (comp[DATA_WIDTH-1 -: 2])
      2'b01:   dst = (src == NC)  ? ONE : src + ONE;
      2'b11:   dst = (src == ONE) ? NC  : src - ONE;
      default: dst = src;
    endcase
  end
endmodule

module motion_update_broadcaster #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int PARTICLE_NUM  = 220,
  parameter int CELL_ID_WIDTH = 4,
  parameter int CELL_NUM_X    = 4,
  parameter int CELL_NUM_Y    = 4,
  parameter int CELL_NUM_Z    = 4
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [3*CELL_ID_WIDTH-1:0] out_rd_cell,
  output logic [ADDR_WIDTH-1:0]      out_rd_address,
  output logic                       out_rden,
  input  logic [3*DATA_WIDTH-1:0]    in_readout,
`ifdef MU_BROADCAST_STALL_EN
  input  logic                       in_stall,
`endif
  output logic                       out_motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]    out_data,
  output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
  output logic                       out_data_valid,
  output logic                       out_busy,
  output logic                       out_done
);
  localparam int STAGES = 2;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_READ_NUM  = 3'd1;
  localparam logic [2:0] S_WAIT_NUM  = 3'd2;
  localparam logic [2:0] S_STREAM    = 3'd3;
  localparam logic [2:0] S_NEXT_CELL = 3'd4;
  localparam logic [2:0] S_DRAIN     = 3'd5;
  localparam logic [2:0] S_TAIL      = 3'd6;

  localparam logic [CELL_ID_WIDTH-1:0] ONE = CELL_ID_WIDTH'(1);
  localparam logic [CELL_ID_WIDTH-1:0] NX  = CELL_ID_WIDTH'(CELL_NUM_X);
  localparam logic [CELL_ID_WIDTH-1:0] NY  = CELL_ID_WIDTH'(CELL_NUM_Y);
  localparam logic [CELL_ID_WIDTH-1:0] NZ  = CELL_ID_WIDTH'(CELL_NUM_Z);
  localparam logic [ADDR_WIDTH-1:0]    PNUM = ADDR_WIDTH'(PARTICLE_NUM);

  typedef struct packed {
    logic [CELL_ID_WIDTH-1:0] x;
    logic [CELL_ID_WIDTH-1:0] y;
    logic [CELL_ID_WIDTH-1:0] z;
  } cell_t;

  logic [2:0]            state;
  cell_t                 cur;
  logic [1:0]            wait_cnt, tail_cnt;
  logic [ADDR_WIDTH-1:0] count, addr_cnt;
  logic [ADDR_WIDTH-1:0] num_raw, num_clamp;
  logic                  fsm_hold;

  logic [STAGES-1:0]                      vld_pipe;
  logic [STAGES-1:0][3*CELL_ID_WIDTH-1:0] cell_pipe;
  logic [2:0][DATA_WIDTH-1:0]             comp_clr;
  logic [2:0][CELL_ID_WIDTH-1:0]          dst_axis;

  assign num_raw   = in_readout[ADDR_WIDTH-1:0];
  assign num_clamp = (num_raw > PNUM) ? PNUM : num_raw;

`ifdef MU_BROADCAST_STALL_EN
  // WAIT_NUM is never held: it must catch the count on its fixed-latency cycle
  assign fsm_hold = in_stall &&
                    (state == S_READ_NUM || state == S_STREAM || state == S_NEXT_CELL);
`else
  assign fsm_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= S_IDLE;
      cur                      <= '{x: ONE, y: ONE, z: ONE};
      wait_cnt                 <= '0;
      tail_cnt                 <= '0;
      count                    <= '0;
      addr_cnt                 <= '0;
      out_rden                 <= 1'b0;
      out_rd_address           <= '0;
      out_rd_cell              <= '0;
      out_motion_update_enable <= 1'b0;
      out_busy                 <= 1'b0;
      out_done                 <= 1'b0;
    end else begin
      out_rden <= 1'b0;
      out_done <= 1'b0;
      if (!fsm_hold) begin
        case (state)
          S_IDLE: if (start) begin
            state                    <= S_READ_NUM;
            cur                      <= '{x: ONE, y: ONE, z: ONE};
            out_motion_update_enable <= 1'b1;
            out_busy                 <= 1'b1;
          end
          S_READ_NUM: begin
            out_rden       <= 1'b1;
            out_rd_address <= '0;
            out_rd_cell    <= cur;
            wait_cnt       <= '0;
            state          <= S_WAIT_NUM;
          end
          S_WAIT_NUM: begin
            if (wait_cnt == 2'd2) begin
              count    <= num_clamp;
              addr_cnt <= ADDR_WIDTH'(1);
              state    <= (num_clamp == '0) ? S_NEXT_CELL : S_STREAM;
            end else begin
              wait_cnt <= wait_cnt + 2'd1;
            end
          end
          S_STREAM: begin
            out_rden       <= 1'b1;
            out_rd_address <= addr_cnt;
            out_rd_cell    <= cur;
            addr_cnt       <= addr_cnt + ADDR_WIDTH'(1);
            if (addr_cnt == count) state <= S_NEXT_CELL;
          end
          S_NEXT_CELL: begin
            if (cur.x != NX) begin
              cur.x <= cur.x + ONE;
              state <= S_READ_NUM;
            end else begin
              cur.x <= ONE;
              if (cur.y != NY) begin
                cur.y <= cur.y + ONE;
                state <= S_READ_NUM;
              end else begin
                cur.y <= ONE;
                if (cur.z != NZ) begin
                  cur.z <= cur.z + ONE;
                  state <= S_READ_NUM;
                end else begin
                  cur.z <= ONE;
                  state <= S_DRAIN;
                end
              end
            end
          end
          // Pipeline empty here means the final broadcast is sitting in the output register
          S_DRAIN: if (!out_rden && vld_pipe == '0) begin
            out_motion_update_enable <= 1'b0;
            tail_cnt                 <= '0;
            state                    <= S_TAIL;
          end
          S_TAIL: begin
            if (tail_cnt == 2'd2) begin
              out_done <= 1'b1;
              out_busy <= 1'b0;
              state    <= S_IDLE;
            end else begin
              tail_cnt <= tail_cnt + 2'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Tracks which reads return particle records, aligned with in_readout
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      cell_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[0], out_rden && (out_rd_address != '0)};
      cell_pipe <= {cell_pipe[0], out_rd_cell};
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_axis
    localparam int NUM = (g == 0) ? CELL_NUM_X : (g == 1) ? CELL_NUM_Y : CELL_NUM_Z;
    mu_axis_resolve #(
      .DATA_WIDTH(DATA_WIDTH), .CELL_ID_WIDTH(CELL_ID_WIDTH), .CELL_NUM(NUM)
    ) u_axis (
      .comp    (in_readout[g*DATA_WIDTH +: DATA_WIDTH]),
      .src     (cell_pipe[STAGES-1][(2-g)*CELL_ID_WIDTH +: CELL_ID_WIDTH]),
      .comp_clr(comp_clr[g]),
      .dst     (dst_axis[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data          <= '0;
      out_data_dst_cell <= '0;
      out_data_valid    <= 1'b0;
    end else begin
      out_data_valid <= vld_pipe[STAGES-1];
      if (vld_pipe[STAGES-1]) begin
        out_data          <= comp_clr;
        out_data_dst_cell <= {dst_axis[0], dst_axis[1], dst_axis[2]};
      end
    end
  end
endmodule

// File: doc/motion_update_broadcaster.md
Name: motion_update_broadcaster

Overview:
- Transmit side of the motion-update broadcast bus consumed by every per-cell double-buffered cache (position/velocity).
- Walks every cell in x-major order and reads the particle count at address 0, then particles 1..N.
- Resolves each particle's destination cell from the cell-crossing flags in its record, then broadcasts the cleared record, destination cell ID and valid flag to all caches.
- Owns motion_update_enable for the whole process.

Parameters:
DATA_WIDTH, 32, width of one component; record is 3*DATA_WIDTH {z,y,x}
ADDR_WIDTH, 8, cell memory address width
PARTICLE_NUM, 220, max particles per cell (count clamp)
CELL_ID_WIDTH, 4, width of one cell coordinate
CELL_NUM_X, 4, cells along x (coords 1..CELL_NUM_X)
CELL_NUM_Y, 4, cells along y
CELL_NUM_Z, 4, cells along z

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse begins a broadcast pass; ignored unless idle
out_rd_cell  out  3*CELL_ID_WIDTH  {x,y,z} of cell being read (selects readout mux)
out_rd_address  out  ADDR_WIDTH  read address
out_rden  out  1  read enable
in_readout  in  3*DATA_WIDTH  selected cell data, valid 2 cycles after out_rden
out_motion_update_enable  out  1  held high for the whole pass
out_data  out  3*DATA_WIDTH  broadcast record, crossing flags cleared
out_data_dst_cell  out  3*CELL_ID_WIDTH  destination {x,y,z}
out_data_valid  out  1  out_data/out_data_dst_cell valid
out_busy  out  1  pass in progress, including tail gap
out_done  out  1  one-cycle pulse at end of pass

Behaviour:
- Interface (already decided): clock clk; reset rst, synchronous, active-high.
- Reset: all outputs 0; FSM to IDLE; cell counters to (1,1,1); pipeline valids cleared. Reset mid-pass aborts immediately with no further valid or done.
- FSM states:
  - IDLE: start -> READ_NUM; set out_motion_update_enable=1 and out_busy=1 in the same edge.
  - READ_NUM: issue rden, addr 0 for the current cell -> WAIT_NUM.
  - WAIT_NUM: 2 cycles; latch count = min(in_readout[ADDR_WIDTH-1:0], PARTICLE_NUM). Count 0 -> NEXT_CELL, else STREAM.
  - STREAM: one read per cycle, addr 1..count; after issuing addr==count -> NEXT_CELL.
  - NEXT_CELL: advance x, then y, then z. Past (NX,NY,NZ) -> DRAIN, else READ_NUM.
  - DRAIN: wait until the read pipeline is empty, plus 1 cycle.
  - TAIL: drop enable, hold 3 cycles (receiver writes its count and flips buffer).
  - TAIL exit: pulse out_done, clear busy -> IDLE.
- Read pipeline: 2-stage shift carrying {is_particle, src_cell}, aligned with in_readout. Only particle reads (addr>=1) produce broadcasts; count reads never do.
- Broadcast latency: registered output. out_data_valid is asserted 3 cycles after the matching out_rden.
- Destination per axis: component bits [DATA_WIDTH-1:DATA_WIDTH-2] encode the crossing.
  - 00 = stay.
  - 01 = +1.
  - 11 = -1.
  - 10 = illegal, treated as stay.
- Periodic wrap: +1 from N -> 1; -1 from 1 -> N. out_data has those 2 bits zeroed per component.
- Last out_data_valid always precedes the enable fall by >=1 cycle.
- Enable rises no later than the first valid.
- start while busy is ignored. Back-to-back passes are separated by >=3 enable-low cycles.

Optional Feature:
- Macro MU_BROADCAST_STALL_EN adds input in_stall (1 bit).
- With the macro: while in_stall=1, no new reads are issued and the FSM holds. In-flight reads still complete and broadcast. Enable stays high.
- Without the macro: no port; the FSM never pauses.

Test Plan:
- Single 1x1x1 grid, count=2, no crossings -> reads addr 0,1,2; two valids 3 cycles after each particle rden; dst=(1,1,1); enable falls 1 cycle after last valid; done after 3 low cycles.
- Default grid, cell (4,1,1) particle x flag 01 -> dst (1,1,1); cell (1,2,1) y flag 11 -> dst (1,1,1); out_data flags zeroed.
- Cell count 0 in every cell but (2,3,4) with count 1 -> exactly 1 valid, src scanned fully, no rden beyond addr 0 elsewhere.
- Count readout 250 with PARTICLE_NUM=220 -> last address issued 220.
- rst asserted mid-STREAM -> next cycle all outputs 0, no done; a new start yields a full clean pass.
- (MU_BROADCAST_STALL_EN) in_stall high 5 cycles mid-STREAM -> address sequence resumes without gaps or duplicates; total valids unchanged.
